rca_serial_sequencer: RTL and testbench

- Sequences one shared 4-bit ripple-carry adder to perform multi-precision addition, one nibble per clock, least significant nibble first.
- Carry is registered between cycles, so a 4*NIBBLES-bit add reuses a single RCA.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready).
- Drives the RCA inputs and samples its sum/carry outputs. The RCA sits outside this block, with port order (s, cout, a, b, ci).

---
 rtl/rca_serial_sequencer.sv | 173 +++++++++++++++++
 tb/tb_rca_serial_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_serial_sequencer.sv
// rca_serial_sequencer
//
// Multi-precision adder sequencer built around one external 4-bit
// ripple-carry adder. Operands of 4*NIBBLES bits are added one nibble per
// clock, least significant nibble first. The carry is held in a register
// between cycles, so the same RCA serves every slice.
//
// Handshakes:
//   producer -> in_valid/in_ready  (operands held until accepted)
//   consumer <- out_valid/out_ready (result held until taken)
//
// The RCA (ports s, cout, a, b, ci) lives outside this block. It is driven
// through rca_a/rca_b/rca_ci and its combinational rca_s/rca_cout are
// sampled on the same edge.
//
// Timing for an accept at cycle T:
//   RUN occupies T+1 .. T+NIBBLES, out_valid is first high at T+NIBBLES+1.
//   A zero-wait consumer sees one operation per NIBBLES+2 cycles.
//
// NIBBLES must lie in 1..16.

module rca_serial_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  // operand side
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_ci,

  // shared ripple-carry adder
  output logic [3:0]             rca_a,
  output logic [3:0]             rca_b,
  output logic                   rca_ci,
  input  logic [3:0]             rca_s,
  input  logic                   rca_cout,

  // result side
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------
  // The slice index needs at least one bit even when there is only one slice.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operands and the sum are kept as arrays of nibbles so the active slice
  // is selected by a plain index rather than by arithmetic on bit offsets.
  typedef logic [NIBBLES-1:0][3:0] nib_vec_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              carry_q, carry_d;
  nib_vec_t          a_q,     a_d;
  nib_vec_t          b_q,     b_d;
  nib_vec_t          sum_q,   sum_d;
  logic              cout_q,  cout_d;

  // Register all state; synchronous reset returns every register to its
  // documented reset value, operand and result registers included.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic and RCA drive for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a value unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    rca_a   = 4'h0;
    rca_b   = 4'h0;
    rca_ci  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the accept.
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Present the current slice and the carry from the previous slice.
        rca_a  = a_q[idx_q];
        rca_b  = b_q[idx_q];
        rca_ci = carry_q;

        // Capture the slice result and carry for the next slice.
        sum_d[idx_q] = rca_s;
        carry_d      = rca_cout;

        if (idx_q == LAST_IDX) begin
          // Final slice: its carry-out is the overall carry-out. The index
          // stays put so it never exceeds NIBBLES-1.
          cout_d  = rca_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        // Result held stable until the consumer takes it.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and status outputs, decoded straight from the state register
  // so they carry their reset values directly out of reset.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_rca_serial_sequencer.sv
// Self-checking bench for rca_serial_sequencer (NIBBLES=4).
// The RCA is modelled as a 5-bit addition wired to the rca_* ports.
// Expected results come from whole-word arithmetic on the operands and are
// queued at accept time; a negedge monitor pops and compares on handoff.

module tb_rca_serial_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_ci;
  logic [3:0]     rca_a;
  logic [3:0]     rca_b;
  logic           rca_ci;
  logic [3:0]     rca_s;
  logic           rca_cout;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic           busy;

  rca_serial_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .rca_a     (rca_a),
    .rca_b     (rca_b),
    .rca_ci    (rca_ci),
    .rca_s     (rca_s),
    .rca_cout  (rca_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  // External 4-bit adder
  assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0000, rca_ci};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0] exp_q[$];     // {cout, sum}
  logic       ci_trace[$];  // rca_ci seen in each RUN cycle
  int         last_accept_cyc = 0;
  int         rise_cyc = 0;
  logic       prev_ov = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    ref_add = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // Scoreboard push on accept, pop/compare on handoff, plus tracing.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(in_a, in_b, in_ci));
        last_accept_cyc = cyc;
      end
      if (busy && !out_valid) ci_trace.push_back(rca_ci);
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got sum 0x%0h cout %0b, expected no result",
                   out_sum, out_cout);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("result_sum", out_sum, e[W-1:0]);
          check("result_cout", out_cout, e[W]);
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_ready);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
      if (rand_ready) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    check("idle_reached", {busy, exp_q.size() != 0}, 0);
    out_ready = 1'b1;
  endtask

  function automatic logic [7:0] trace_bits();
    logic [7:0] v = '0;
    for (int i = 0; i < ci_trace.size() && i < 8; i++) v[i] = ci_trace[i];
    return v;
  endfunction

  initial begin
    int acc[$];
    int k;
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];
    logic         pc[3];

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_rca", {rca_a, rca_b, rca_ci}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic add, latency and carry-free chain
    ci_trace.delete();
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_idle(0);
    check("latency", rise_cyc - last_accept_cyc, NIBBLES + 1);
    check("ci_trace_len_1", ci_trace.size(), 4);
    check("ci_trace_1", trace_bits(), 8'b0000_0000);

    // Carry ripples across registered slices: rca_ci 0,1,1,1
    ci_trace.delete();
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_idle(0);
    check("ci_trace_len_2", ci_trace.size(), 4);
    check("ci_trace_2", trace_bits(), 8'b0000_1110);

    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_idle(0);
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_idle(0);
    start_op(16'h0000, 16'h0000, 1'b1);
    wait_idle(0);

    // Backpressure: result held, new requests ignored
    out_ready = 1'b0;
    start_op(16'h00FF, 16'h0F0F, 1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_sum", out_sum, 16'h100E);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);                     // handoff seen by monitor here
    @(negedge clk);
    check("bp_after_valid", out_valid, 0);
    check("bp_after_ready", in_ready, 1);
    check("bp_drained", exp_q.size(), 0);

    // Reset while RUN is on slice 2
    start_op(16'h1111, 16'h2222, 1'b0);   // returns in RUN slice 0
    @(posedge clk); #1;                   // slice 1
    @(posedge clk); #1;                   // slice 2
    check("pre_rst_busy", {busy, out_valid}, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sum", out_sum, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    exp_q.delete();                       // aborted op never produces a result
    start_op(16'h0007, 16'h0009, 1'b0);
    wait_idle(0);

    // Back-to-back with in_valid held high
    pa[0] = 16'hA5A5; pb[0] = 16'h5A5A; pc[0] = 1'b1;
    pa[1] = 16'h1357; pb[1] = 16'hFDB9; pc[1] = 1'b0;
    pa[2] = 16'h7FFF; pb[2] = 16'h0001; pc[2] = 1'b1;
    k = 0;
    @(posedge clk); #1;
    in_a = pa[0]; in_b = pb[0]; in_ci = pc[0]; in_valid = 1'b1;
    for (int c = 0; c < 60 && k < 3; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc.push_back(cyc);
        k++;
        @(posedge clk); #1;
        if (k < 3) begin
          in_a = pa[k]; in_b = pb[k]; in_ci = pc[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      check("b2b_spacing_0", acc[1] - acc[0], NIBBLES + 2);
      check("b2b_spacing_1", acc[2] - acc[1], NIBBLES + 2);
    end
    wait_idle(0);

    // Randomized operands with a random-ready consumer
    for (int i = 0; i < 25; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      wait_idle(1);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
